// File: rtl/mac_seq_ctrl.sv
// Sequencer for one signed MAC: streams a dot product of len operand pairs from the data and
// weight buffers, waits out the MAC pipeline, then hands the result over with valid/ready.
module mac_seq_ctrl #(
  parameter int unsigned IN_BIT     = 8,
  parameter int unsigned WEIGHT_BIT = 8,
  parameter int unsigned OUT_BIT    = 20,
  parameter int unsigned OP_BIT     = 2,
  parameter int unsigned LEN_BIT    = 10,
  parameter int unsigned ADDR_BIT   = 10,
  parameter int unsigned MAC_LAT    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_BIT-1:0]  len,
  input  logic [ADDR_BIT-1:0] data_base,
  input  logic [ADDR_BIT-1:0] weight_base,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [ADDR_BIT-1:0] data_addr,
  output logic [ADDR_BIT-1:0] weight_addr,
  output logic                mac_ena,
  output logic [OP_BIT-1:0]   mac_op,
  input  logic [OUT_BIT-1:0]  mac_result,
  output logic [OUT_BIT-1:0]  result,
  output logic                result_valid,
  input  logic                result_ready
);

  localparam int unsigned DrainBit = $clog2(MAC_LAT + 1);

  localparam logic [OP_BIT-1:0] OpHold = OP_BIT'(0);
  localparam logic [OP_BIT-1:0] OpLoad = OP_BIT'(1);
  localparam logic [OP_BIT-1:0] OpAcc  = OP_BIT'(2);

  // Operand widths only matter to the MAC; the result is passed through as OUT_BIT bits.
  if (IN_BIT + WEIGHT_BIT > 2 * OUT_BIT) begin : g_wide_operands
  end

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StOut} state_e;

  state_e              state;
  logic [LEN_BIT-1:0]  remain;
  logic [DrainBit-1:0] drain_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      remain       <= '0;
      drain_cnt    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_en        <= 1'b0;
      data_addr    <= '0;
      weight_addr  <= '0;
      mac_ena      <= 1'b0;
      mac_op       <= OpHold;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      done    <= 1'b0;
      // One register stage behind the read strobe, matching the buffer read latency.
      mac_ena <= rd_en;
      if (rd_en) begin
        mac_op <= mac_ena ? OpAcc : OpLoad;
      end else begin
        mac_op <= OpHold;
      end

      unique case (state)
        StIdle: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              state       <= StFetch;
              rd_en       <= 1'b1;
              data_addr   <= data_base;
              weight_addr <= weight_base;
              remain      <= len - 1'b1;
            end else begin
              state        <= StOut;
              result       <= '0;
              result_valid <= 1'b1;
            end
          end
        end
        StFetch: begin
          if (remain == '0) begin
            rd_en     <= 1'b0;
            drain_cnt <= '0;
            state     <= StDrain;
          end else begin
            remain      <= remain - 1'b1;
            data_addr   <= data_addr + 1'b1;
            weight_addr <= weight_addr + 1'b1;
          end
        end
        StDrain: begin
          // Entered on the last mac_ena cycle; the MAC output is final MAC_LAT cycles later.
          if (drain_cnt == DrainBit'(MAC_LAT)) begin
            result       <= mac_result;
            result_valid <= 1'b1;
            state        <= StOut;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        StOut: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: behavioural buffers and MAC around the DUT, dot products checked
// against a plain-arithmetic reference.
module tb_mac_seq_ctrl;

  localparam int MacLat = 2;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [9:0]         len;
  logic [9:0]         data_base;
  logic [9:0]         weight_base;
  logic               busy;
  logic               done;
  logic               rd_en;
  logic [9:0]         data_addr;
  logic [9:0]         weight_addr;
  logic               mac_ena;
  logic [1:0]         mac_op;
  logic signed [19:0] mac_result;
  logic [19:0]        result;
  logic               result_valid;
  logic               result_ready;

  int tests = 0;
  int fails = 0;

  mac_seq_ctrl #(
    .IN_BIT(8), .WEIGHT_BIT(8), .OUT_BIT(20), .OP_BIT(2), .LEN_BIT(10), .ADDR_BIT(10),
    .MAC_LAT(MacLat)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .data_base(data_base),
    .weight_base(weight_base), .busy(busy), .done(done), .rd_en(rd_en),
    .data_addr(data_addr), .weight_addr(weight_addr), .mac_ena(mac_ena), .mac_op(mac_op),
    .mac_result(mac_result), .result(result), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: 1-cycle-latency buffers and a MAC whose output trails its last enable by MacLat.
  logic signed [7:0]  dmem [1024];
  logic signed [7:0]  wmem [1024];
  logic signed [7:0]  rd_data;
  logic signed [7:0]  rd_weight;
  logic signed [19:0] acc;

  initial begin
    acc        = '0;
    mac_result = '0;
    rd_data    = '0;
    rd_weight  = '0;
  end

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data   <= dmem[data_addr];
      rd_weight <= wmem[weight_addr];
    end
    if (mac_ena && mac_op == 2'b01) acc <= rd_data * rd_weight;
    else if (mac_ena && mac_op == 2'b10) acc <= acc + rd_data * rd_weight;
    mac_result <= acc;
  end

  // Observed read addresses and op codes of the current run.
  logic [9:0] daq[$];
  logic [9:0] waq[$];
  logic [1:0] opq[$];
  int         bad_ops = 0;

  always @(negedge clk) begin
    if (rd_en) begin
      daq.push_back(data_addr);
      waq.push_back(weight_addr);
    end
    if (mac_ena) opq.push_back(mac_op);
    if ((!mac_ena && mac_op != 2'b00) || mac_op == 2'b11) bad_ops++;
  end

  function automatic logic [19:0] ref_dot(input int n, input int db, input int wb);
    longint s = 0;
    for (int k = 0; k < n; k++) s += dmem[(db + k) % 1024] * wmem[(wb + k) % 1024];
    return s[19:0];
  endfunction

  function automatic bit seq_ok(input int n, input int db, input int wb);
    if (daq.size() != n || waq.size() != n || opq.size() != n) return 1'b0;
    for (int k = 0; k < n; k++) begin
      if (daq[k] != 10'((db + k) % 1024)) return 1'b0;
      if (waq[k] != 10'((wb + k) % 1024)) return 1'b0;
      if (opq[k] != ((k == 0) ? 2'b01 : 2'b10)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int exp_lat(input int n);
    return (n == 0) ? 0 : n + 1 + MacLat;
  endfunction

  task automatic issue(input int n, input int db, input int wb);
    @(negedge clk);
    daq.delete();
    waq.delete();
    opq.delete();
    start       = 1'b1;
    len         = 10'(n);
    data_base   = 10'(db);
    weight_base = 10'(wb);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in the first cycle after acceptance; cyc-1 is the delay from that cycle to valid.
  task automatic wait_valid(input int budget, output int cyc);
    cyc = 1;
    while (result_valid !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Leaves the caller in the cycle after the handshake.
  task automatic handshake(input int delay);
    repeat (delay) @(negedge clk);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = 8'($urandom);
      wmem[i] = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    int cyc;
    tests++;
    if ({busy, done, rd_en, mac_ena, result_valid, mac_op, data_addr, weight_addr, result} !== '0)
    begin
      fails++;
      $display("FAIL reset_state: outputs %b, required all zero",
               {busy, done, rd_en, mac_ena, result_valid, mac_op, data_addr, weight_addr, result});
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(8, 10, 20);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, rd_en, mac_ena, result_valid, mac_op, data_addr, weight_addr, result} !== '0)
    begin
      fails++;
      $display("FAIL reset_mid_fetch: outputs %b, required all zero",
               {busy, done, rd_en, mac_ena, result_valid, mac_op, data_addr, weight_addr, result});
    end
    @(negedge clk);
    rst_n   = 1'b1;
    dmem[0] = 8'sd3;
    wmem[0] = -8'sd4;
    issue(1, 0, 0);
    wait_valid(20, cyc);
    tests++;
    if (result_valid !== 1'b1 || cyc - 1 != 4) begin
      fails++;
      $display("FAIL single_latency: valid=%b after %0d cycles, required 1 after 4",
               result_valid, cyc - 1);
    end
    tests++;
    if (result !== 20'hFFFF4 || seq_ok(1, 0, 0) !== 1'b1) begin
      fails++;
      $display("FAIL single_result: result=%0d ops=%0d, required -12 with one LOAD",
               $signed(result), opq.size());
    end
    handshake(0);
  endtask

  task automatic test_basic();
    int cyc;
    for (int i = 0; i < 4; i++) begin
      dmem[100 + i] = 8'(i + 1);
      wmem[100 + i] = 8'(i + 5);
    end
    issue(4, 100, 100);
    wait_valid(30, cyc);
    tests++;
    if (result !== 20'd70 || cyc - 1 != exp_lat(4)) begin
      fails++;
      $display("FAIL basic_result: result=%0d lat=%0d, required 70 lat=%0d",
               $signed(result), cyc - 1, exp_lat(4));
    end
    tests++;
    if (seq_ok(4, 100, 100) !== 1'b1) begin
      fails++;
      $display("FAIL basic_sequence: %0d reads %0d ops, required 4 reads LOAD,ACC,ACC,ACC",
               daq.size(), opq.size());
    end
    tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_pre_done: done=%b busy=%b, required done=0 busy=1", done, busy);
    end
    handshake(0);
    tests++;
    if ({done, busy, result_valid} !== 3'b100) begin
      fails++;
      $display("FAIL basic_done: done,busy,valid=%b, required 100", {done, busy, result_valid});
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_pulse: done=%b, required 0 one cycle later", done);
    end
  endtask

  task automatic test_zero_len();
    int cyc;
    issue(0, 5, 7);
    wait_valid(10, cyc);
    tests++;
    if (result_valid !== 1'b1 || cyc != 1 || result !== 20'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL zero_len: valid=%b cyc=%0d result=%0d busy=%b, required 1,1,0,1",
               result_valid, cyc, $signed(result), busy);
    end
    handshake(1);
    tests++;
    if (done !== 1'b1 || daq.size() != 0 || opq.size() != 0) begin
      fails++;
      $display("FAIL zero_len_done: done=%b reads=%0d enables=%0d, required 1,0,0",
               done, daq.size(), opq.size());
    end
  endtask

  task automatic test_backpressure();
    int          cyc;
    logic [19:0] exp;
    fill_random();
    issue(3, 200, 300);
    exp = ref_dot(3, 200, 300);
    wait_valid(30, cyc);
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0);
      len   = 10'd5;
      @(negedge clk);
      tests++;
      if (result !== exp || result_valid !== 1'b1 || busy !== 1'b1 || rd_en !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold[%0d]: result=%0d valid=%b busy=%b rd_en=%b, required %0d,1,1,0",
                 i, $signed(result), result_valid, busy, rd_en, $signed(exp));
      end
    end
    start = 1'b0;
    handshake(0);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || rd_en !== 1'b0 || seq_ok(3, 200, 300) !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_ignored_start: busy=%b rd_en=%b reads=%0d, required 0,0,3",
               busy, rd_en, daq.size());
    end
  endtask

  task automatic test_addr_wrap();
    int cyc;
    fill_random();
    issue(4, 1022, 1021);
    wait_valid(30, cyc);
    tests++;
    if (seq_ok(4, 1022, 1021) !== 1'b1 || result !== ref_dot(4, 1022, 1021)) begin
      fails++;
      $display("FAIL addr_wrap: first addrs %0d..%0d result=%0d, required 1022..1 result=%0d",
               daq.size() > 0 ? daq[0] : -1, daq.size() > 0 ? daq[daq.size() - 1] : -1,
               $signed(result), $signed(ref_dot(4, 1022, 1021)));
    end
    handshake(2);
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int i = 0; i < 4; i++) begin
      dmem[500 + i] = -8'sd128;
      wmem[600 + i] = -8'sd128;
    end
    issue(2, 500, 600);
    wait_valid(30, cyc);
    tests++;
    if (result !== 20'd32768 || seq_ok(2, 500, 600) !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: result=%0d, required 32768", $signed(result));
    end
    handshake(0);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_done: done=%b, required 1", done);
    end
    daq.delete();
    waq.delete();
    opq.delete();
    start       = 1'b1;
    len         = 10'd2;
    data_base   = 10'd502;
    weight_base = 10'd602;
    @(negedge clk);
    start = 1'b0;
    wait_valid(30, cyc);
    tests++;
    if (result !== 20'd32768 || cyc - 1 != exp_lat(2) || seq_ok(2, 502, 602) !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second: result=%0d lat=%0d ops=%0d, required 32768 lat=%0d LOAD,ACC",
               $signed(result), cyc - 1, opq.size(), exp_lat(2));
    end
    handshake(0);
  endtask

  task automatic test_random();
    int cyc;
    int n;
    int db;
    int wb;
    for (int r = 0; r < 8; r++) begin
      fill_random();
      n  = (r == 7) ? 1023 : int'($urandom_range(1, 40));
      db = int'($urandom_range(0, 1023));
      wb = int'($urandom_range(0, 1023));
      issue(n, db, wb);
      wait_valid(n + 20, cyc);
      tests++;
      if (result_valid !== 1'b1 || result !== ref_dot(n, db, wb) || cyc - 1 != exp_lat(n)
          || seq_ok(n, db, wb) !== 1'b1) begin
        fails++;
        $display("FAIL random_run[%0d] len=%0d: result=%0d lat=%0d, required %0d lat=%0d",
                 r, n, $signed(result), cyc - 1, $signed(ref_dot(n, db, wb)), exp_lat(n));
      end
      handshake(int'($urandom_range(0, 3)));
    end
    tests++;
    if (bad_ops != 0) begin
      fails++;
      $display("FAIL op_hold: %0d cycles with bad op code, required 0", bad_ops);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    len          = '0;
    data_base    = '0;
    weight_base  = '0;
    result_ready = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = '0;
      wmem[i] = '0;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_addr_wrap();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
